bin_lookup_requester: RTL and testbench

Initiator side of the BIN search handshake. Collects six keypad digits and drives start plus the stable d5..d0 digits into the BIN binary-search block. Waits for done and latches found/index. On a hit, reads the matching bank/brand/type/level record from the info ROM. Presents one result to the display/UI logic and holds it until acknowledged.

---
 rtl/bin_lookup_requester.sv | 212 +++++++++++++++++++++
 tb/tb_bin_lookup_requester.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_lookup_requester.sv
// Purpose: collect a 6-digit BIN from the keypad, run one search handshake, fetch the info record on a hit.
// Latency: result_valid rises 1 cycle after search_done falls on a miss, 2 cycles after on a hit.
// Backpressure: one result is held in S_RESULT until result_ack; keys are ignored while busy.
// Optional watchdog: define BIN_REQ_TIMEOUT_EN to abort a search after TIMEOUT_CYCLES.
module bin_lookup_requester #(
  parameter int INDEX_W        = 12,
  parameter int INFO_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [3:0]         key_digit,
  input  logic               key_clear,
  input  logic               key_enter,
  output logic               search_start,
  output logic [3:0]         search_d5,
  output logic [3:0]         search_d4,
  output logic [3:0]         search_d3,
  output logic [3:0]         search_d2,
  output logic [3:0]         search_d1,
  output logic [3:0]         search_d0,
  input  logic               search_done,
  input  logic               search_found,
  input  logic [INDEX_W-1:0] search_index,
  output logic [INDEX_W-1:0] info_addr,
  input  logic [INFO_W-1:0]  info_rdata,
  output logic               busy,
  output logic [2:0]         digit_count,
  output logic               entry_err,
  output logic               result_valid,
  output logic               result_found,
  output logic [INDEX_W-1:0] result_index,
  output logic [INFO_W-1:0]  result_info,
  output logic               result_timeout,
  input  logic               result_ack
);

  typedef enum logic [2:0] {
    S_ENTRY, S_REQ, S_WAIT_DONE, S_RELEASE, S_INFO, S_RESULT
  } state_t;

  state_t               state_q, state_d;
  logic [23:0]          dig_q, dig_d;      // d5 in [23:20], newest digit in [3:0]
  logic [2:0]           count_q, count_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 found_q, found_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [INFO_W-1:0]    info_q, info_d;
`ifdef BIN_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 timeout_q, timeout_d;
`endif

  // Next-state, key handling, handshake sequencing and result capture
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    count_d = count_q;
    start_d = start_q;
    err_d   = 1'b0;
    valid_d = valid_q;
    found_d = found_q;
    index_d = index_q;
    info_d  = info_q;
`ifdef BIN_REQ_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_ENTRY: begin
        if (key_clear) begin
          // Clear wins over any digit or enter in the same cycle
          dig_d   = '0;
          count_d = '0;
        end else begin
          if (key_valid && (key_digit <= 4'd9) && (count_q < 3'd6)) begin
            dig_d   = {dig_q[19:0], key_digit};
            count_d = count_q + 3'd1;
          end
          // Enter is judged on the count before this edge
          if (key_enter) begin
            if (count_q == 3'd6) begin
              state_d = S_REQ;
`ifdef BIN_REQ_TIMEOUT_EN
              tmo_d = '0;
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_REQ: begin
        // Never start while a previous search still shows done
        if (!search_done) begin
          start_d = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (search_done) begin
          found_d = search_found;
          index_d = search_found ? search_index : '0;
          start_d = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!search_done) begin
          if (found_q) begin
            state_d = S_INFO;
          end else begin
            info_d  = '0;
            valid_d = 1'b1;
            state_d = S_RESULT;
          end
        end
      end
      S_INFO: begin
        // info_addr has been stable since the done edge, so rdata is current
        info_d  = info_rdata;
        valid_d = 1'b1;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (result_ack) begin
          valid_d = 1'b0;
          dig_d   = '0;
          count_d = '0;
          found_d = 1'b0;
          index_d = '0;
          info_d  = '0;
`ifdef BIN_REQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = S_ENTRY;
        end
      end
      default: state_d = S_ENTRY;
    endcase
`ifdef BIN_REQ_TIMEOUT_EN
    // Watchdog overrides the handshake once the limit is reached
    if ((state_q == S_WAIT_DONE) || (state_q == S_RELEASE)) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
        start_d   = 1'b0;
        timeout_d = 1'b1;
        found_d   = 1'b0;
        index_d   = '0;
        info_d    = '0;
        valid_d   = 1'b1;
        state_d   = S_RESULT;
      end
    end
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ENTRY;
      dig_q   <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      index_q <= '0;
      info_q  <= '0;
`ifdef BIN_REQ_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      count_q <= count_d;
      start_q <= start_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      found_q <= found_d;
      index_q <= index_d;
      info_q  <= info_d;
`ifdef BIN_REQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign search_start = start_q;
  assign {search_d5, search_d4, search_d3, search_d2, search_d1, search_d0} = dig_q;
  assign info_addr    = index_q;
  assign busy         = (state_q != S_ENTRY);
  assign digit_count  = count_q;
  assign entry_err    = err_q;
  assign result_valid = valid_q;
  assign result_found = found_q;
  assign result_index = index_q;
  assign result_info  = info_q;
`ifdef BIN_REQ_TIMEOUT_EN
  assign result_timeout = timeout_q;
`else
  // Watchdog not built: the flag is constant 0 for any positive limit
  assign result_timeout = (TIMEOUT_CYCLES < 1);
`endif

endmodule

// File: tb/tb_bin_lookup_requester.sv
// Directed bench for bin_lookup_requester with a behavioural searcher stub and info ROM.
// Expected values are hand-computed constants; the stub/ROM only generate stimulus.
module tb_bin_lookup_requester;
  localparam int IW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid, key_clear, key_enter, result_ack;
  logic [3:0]    key_digit;
  logic          search_start, search_done, search_found;
  logic [3:0]    search_d5, search_d4, search_d3, search_d2, search_d1, search_d0;
  logic [IW-1:0] search_index, info_addr, result_index;
  logic [DW-1:0] info_rdata, result_info;
  logic          busy, entry_err, result_valid, result_found, result_timeout;
  logic [2:0]    digit_count;

  int n_checks = 0;
  int n_fail   = 0;

  bin_lookup_requester #(.INDEX_W(IW), .INFO_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear), .key_enter(key_enter),
    .search_start(search_start),
    .search_d5(search_d5), .search_d4(search_d4), .search_d3(search_d3),
    .search_d2(search_d2), .search_d1(search_d1), .search_d0(search_d0),
    .search_done(search_done), .search_found(search_found), .search_index(search_index),
    .info_addr(info_addr), .info_rdata(info_rdata),
    .busy(busy), .digit_count(digit_count), .entry_err(entry_err),
    .result_valid(result_valid), .result_found(result_found), .result_index(result_index),
    .result_info(result_info), .result_timeout(result_timeout), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  // Info ROM: 1-cycle registered read
  always @(posedge clk)
    info_rdata <= (info_addr == 12'd31) ? 32'hDEADBEEF : {20'hABCDE, info_addr};

  // Searcher stub: done after stub_delay cycles of start, held until start drops,
  // then released stub_drop cycles later
  int   stub_delay = 10;
  int   stub_drop  = 0;
  bit   stub_found = 1'b1;
  bit   stub_never = 1'b0;
  logic [IW-1:0] stub_index = '0;
  int   sc = 0;
  bit   sphase = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      search_done <= 1'b0; search_found <= 1'b0; search_index <= '0; sc <= 0; sphase <= 1'b0;
    end else if (!sphase) begin
      if (search_start && !stub_never) begin
        if (sc >= stub_delay - 1) begin
          search_done <= 1'b1; search_found <= stub_found; search_index <= stub_index;
          sphase <= 1'b1; sc <= 0;
        end else sc <= sc + 1;
      end
    end else if (!search_start) begin
      if (sc >= stub_drop) begin
        search_done <= 1'b0; sphase <= 1'b0; sc <= 0;
      end else sc <= sc + 1;
    end
  end

  // Observer, sampled 2 time units after each rising edge
  int cyc = 0, t_drop = 0, t_valid = 0, both_hi = 0, restart_viol = 0, start_hi = 0;
  logic prev_done = 1'b0, prev_start = 1'b0, prev_valid = 1'b0;
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (prev_done && !search_done) t_drop = cyc;
    if (!prev_valid && result_valid) t_valid = cyc;
    if (search_done && search_start) both_hi = both_hi + 1;
    if (!prev_start && search_start && search_done) restart_viol = restart_viol + 1;
    if (search_start) start_hi = start_hi + 1;
    prev_done = search_done; prev_start = search_start; prev_valid = result_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_enter();
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask

  task automatic enter_bin(input logic [23:0] bin);
    for (int i = 5; i >= 0; i--) press(bin[i*4 +: 4]);
  endtask

  function automatic logic [23:0] digits();
    return {search_d5, search_d4, search_d3, search_d2, search_d1, search_d0};
  endfunction

  task automatic wait_result(input string tag);
    int n = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) check_eq({tag, "_result_wait"}, 64'd0, 64'd1);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  initial begin
    int b0, s0;
    reset = 1'b1; key_valid = 1'b0; key_digit = '0; key_clear = 1'b0;
    key_enter = 1'b0; result_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", digit_count, 0);
    check_eq("rst_start", search_start, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_info_addr", info_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Hit: index 31 -> DEADBEEF
    stub_delay = 10; stub_found = 1'b1; stub_index = 12'd31; stub_drop = 0;
    enter_bin(24'h453201);
    check_eq("hit_count6", digit_count, 6);
    check_eq("hit_digits", digits(), 24'h453201);
    b0 = both_hi;
    press_enter();
    wait_result("hit");
    check_eq("hit_found", result_found, 1);
    check_eq("hit_index", result_index, 31);
    check_eq("hit_info", result_info, 32'hDEADBEEF);
    check_eq("hit_timeout", result_timeout, 0);
    check_eq("hit_digits_held", digits(), 24'h453201);
    check_eq("hit_latency", t_valid - t_drop, 2);
    check_eq("hit_start_done_overlap", both_hi - b0, 1);
    check_eq("hit_start_low", search_start, 0);
    repeat (3) @(negedge clk);
    check_eq("hit_valid_hold", result_valid, 1);
    ack();
    check_eq("ack_valid", result_valid, 0);
    check_eq("ack_count", digit_count, 0);
    check_eq("ack_busy", busy, 0);

    // Miss: index/info forced to 0, no S_INFO cycle
    stub_found = 1'b0; stub_index = 12'd77;
    enter_bin(24'h453201);
    press_enter();
    wait_result("miss");
    check_eq("miss_found", result_found, 0);
    check_eq("miss_index", result_index, 0);
    check_eq("miss_info", result_info, 0);
    check_eq("miss_latency", t_valid - t_drop, 1);
    ack();

    // Short entry, same-cycle digit+enter, clear priority, invalid/extra digits
    for (int i = 1; i <= 5; i++) press(4'(i));
    press_enter();
    check_eq("err_pulse", entry_err, 1);
    check_eq("err_busy", busy, 0);
    @(negedge clk);
    check_eq("err_one_cycle", entry_err, 0);
    check_eq("err_no_start", search_start, 0);
    check_eq("err_count5", digit_count, 5);
    key_valid = 1'b1; key_digit = 4'd6; key_enter = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_enter = 1'b0;
    check_eq("enter_digit_err", entry_err, 1);
    check_eq("enter_digit_count", digit_count, 6);
    check_eq("enter_digit_idle", busy, 0);
    key_clear = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    @(negedge clk);
    key_clear = 1'b0; key_valid = 1'b0;
    check_eq("clear_count", digit_count, 0);
    check_eq("clear_digits", digits(), 0);
    press(4'd1); press(4'hA); press(4'd2); press(4'd9);
    press(4'd3); press(4'd4); press(4'd5); press(4'd6);
    check_eq("mixed_count", digit_count, 6);
    check_eq("mixed_digits", digits(), 24'h129345);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;

    // Slow done release, back-to-back searches
    stub_delay = 3; stub_drop = 1; stub_found = 1'b1; stub_index = 12'd5;
    b0 = both_hi;
    enter_bin(24'h111111);
    press_enter();
    wait_result("b2b1");
    check_eq("b2b1_index", result_index, 5);
    check_eq("b2b1_info", result_info, 32'hABCDE005);
    check_eq("b2b1_overlap", both_hi - b0, 1);
    ack();
    stub_index = 12'd6;
    enter_bin(24'h222222);
    press_enter();
    wait_result("b2b2");
    check_eq("b2b2_index", result_index, 6);
    check_eq("b2b2_info", result_info, 32'hABCDE006);
    check_eq("b2b2_digits", digits(), 24'h222222);
    check_eq("b2b_restart_viol", restart_viol, 0);
    ack();

    // Reset while waiting for done
    stub_delay = 50; stub_drop = 0;
    enter_bin(24'h987654);
    press_enter();
    for (int i = 0; i < 20 && !search_start; i++) @(negedge clk);
    check_eq("midrst_started", search_start, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_start", search_start, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_count", digit_count, 0);
    check_eq("midrst_results", {result_valid, result_found, result_index, result_info, result_timeout}, 0);
    check_eq("midrst_digits", digits(), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef BIN_REQ_TIMEOUT_EN
    // Watchdog: searcher never answers
    stub_never = 1'b1;
    enter_bin(24'h123456);
    s0 = start_hi;
    press_enter();
    wait_result("tmo");
    check_eq("tmo_flag", result_timeout, 1);
    check_eq("tmo_found", result_found, 0);
    check_eq("tmo_index", result_index, 0);
    check_eq("tmo_info", result_info, 0);
    check_eq("tmo_start", search_start, 0);
    check_eq("tmo_start_cycles", start_hi - s0, 16);
    ack();
    check_eq("tmo_ack_flag", result_timeout, 0);
`else
    s0 = start_hi;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
